down_counter_timer: RTL and testbench

Loadable down-counter with terminal-count detection; the count-down counterpart of the team's toggle-enabled up-counter. A value is loaded over a valid/ready handshake, decremented on each clock where the enable `T` is high, and a one-cycle terminal-count pulse `tc` fires when the count reaches zero. Optional auto-reload makes it a periodic tick generator for the surrounding datapath.

---
 rtl/down_counter_timer.sv | 101 ++++++++++
 tb/tb_down_counter_timer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// Loadable down-counter with terminal-count pulse. A value loaded over
// valid/ready counts down on T; tc fires for one cycle at the terminal edge.
module down_counter_timer #(
  parameter int WIDTH       = 3,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             T,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_val,
  output logic             load_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             zero,
  output logic             tc
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;
  logic             busy_q, ready_q;
  logic             load_acc;

  assign load_acc = load_valid && ready_q;

  // An accepted handshake always wins in IDLE/DONE: once ready was shown, the
  // producer considers the value taken, so abort cannot drop it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (load_acc) begin
          cnt_d = load_val;
          if (load_val != '0) begin
            rld_d   = load_val;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (T) begin
          if (cnt_q == ONE) begin
            tc_d = 1'b1;
            if (AUTO_RELOAD) begin
              cnt_d = rld_q;
            end else begin
              cnt_d   = '0;
              state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // busy/load_ready are registered decodes of the next state so they line up
  // with Q and tc on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rld_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == RUN);
      ready_q <= (state_d != RUN);
    end
  end

  assign Q          = cnt_q;
  assign busy       = busy_q;
  assign load_ready = ready_q;
  assign tc         = tc_q;
  assign zero       = (cnt_q == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench: one instance without and one with auto-reload, WIDTH=3.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       a_T = 0, a_lv = 0, a_ab = 0;
  logic [2:0] a_lval = '0;
  logic       a_rdy, a_busy, a_zero, a_tc;
  logic [2:0] a_Q;

  logic       b_T = 0, b_lv = 0, b_ab = 0;
  logic [2:0] b_lval = '0;
  logic       b_rdy, b_busy, b_zero, b_tc;
  logic [2:0] b_Q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(3), .AUTO_RELOAD(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .T(a_T), .load_valid(a_lv), .load_val(a_lval),
    .load_ready(a_rdy), .abort(a_ab), .Q(a_Q), .busy(a_busy), .zero(a_zero), .tc(a_tc)
  );

  down_counter_timer #(.WIDTH(3), .AUTO_RELOAD(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .T(b_T), .load_valid(b_lv), .load_val(b_lval),
    .load_ready(b_rdy), .abort(b_ab), .Q(b_Q), .busy(b_busy), .zero(b_zero), .tc(b_tc)
  );

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // one active edge, then settle on the falling edge for driving/sampling
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_a(input string tag, input int q, input int bsy, input int rdy, input int t);
    chk({tag, ".Q"},    a_Q,    q);
    chk({tag, ".busy"}, a_busy, bsy);
    chk({tag, ".rdy"},  a_rdy,  rdy);
    chk({tag, ".tc"},   a_tc,   t);
    chk({tag, ".zero"}, a_zero, (q == 0) ? 1 : 0);
  endtask

  int tcs;
  int bq [9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
  int bt [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};

  initial begin
    #1 rst_n = 1'b0;
    step();
    step();
    chk_a("rst", 0, 0, 1, 0);
    chk("rst.b_rdy", b_rdy, 1);
    rst_n = 1'b1;
    step();

    // load 5, T high throughout: 5,4,3,2,1,0 with tc on the 0 cycle
    a_lv = 1; a_lval = 3'd5; a_T = 1;
    step();
    a_lv = 0;
    chk_a("ld5", 5, 1, 0, 0);
    for (int i = 4; i >= 1; i--) begin
      step();
      chk_a($sformatf("dn%0d", i), i, 1, 0, 0);
    end
    step();
    chk_a("term5", 0, 0, 1, 1);
    step();
    chk_a("done5", 0, 0, 1, 0);

    // load 3, T = 1,0,0,1,1 with an ignored load attempt of 6 mid-run
    a_lv = 1; a_lval = 3'd3; a_T = 0;
    step();
    a_lv = 0;
    chk_a("ld3", 3, 1, 0, 0);
    tcs = 0;
    a_T = 1; step(); chk("p1.Q", a_Q, 2); tcs += a_tc;
    a_T = 0; a_lv = 1; a_lval = 3'd6;
    step(); chk("p2.Q", a_Q, 2); chk("p2.rdy", a_rdy, 0); tcs += a_tc;
    a_lv = 0;
    step(); chk("p3.Q", a_Q, 2); tcs += a_tc;
    a_T = 1; step(); chk("p4.Q", a_Q, 1); tcs += a_tc;
    step(); chk_a("p5", 0, 0, 1, 1); tcs += a_tc;
    chk("p.tc_count", tcs, 1);

    // back-to-back load on the tc cycle, two decrements, then abort with T
    a_lv = 1; a_lval = 3'd4;
    step();
    a_lv = 0;
    chk_a("ld4", 4, 1, 0, 0);
    step(); chk("ab.d1", a_Q, 3);
    step(); chk("ab.d2", a_Q, 2);
    a_ab = 1;
    step();
    a_ab = 0;
    chk_a("abort", 2, 0, 1, 0);
    step();
    chk_a("idle_hold", 2, 0, 1, 0);

    // reset mid-count, no clock edge between assert and check
    a_lv = 1; a_lval = 3'd3; a_T = 0;
    step();
    a_lv = 0;
    chk_a("pre_rst", 3, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_a("async_rst", 0, 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_a("post_rst", 0, 0, 1, 0);

    // load 0 from IDLE: straight to DONE, never tc or busy
    a_lv = 1; a_lval = 3'd0; a_T = 1;
    step();
    a_lv = 0;
    chk_a("ld0", 0, 0, 1, 0);
    step();
    chk_a("ld0_hold", 0, 0, 1, 0);

    // full range load of 7: tc only on the 7th T edge
    a_lv = 1; a_lval = 3'd7;
    step();
    a_lv = 0;
    chk("ld7.Q", a_Q, 7);
    tcs = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      tcs += a_tc;
      chk($sformatf("f7.Q%0d", i), a_Q, 7 - i);
    end
    chk("f7.tc_count", tcs, 1);
    chk("f7.tc_last", a_tc, 1);
    a_T = 0;

    // auto-reload: load 3, nine T edges, tc every third
    b_lv = 1; b_lval = 3'd3; b_T = 1;
    step();
    b_lv = 0;
    chk("b.ld3.Q", b_Q, 3);
    chk("b.ld3.busy", b_busy, 1);
    tcs = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      tcs += b_tc;
      chk($sformatf("b.Q%0d", i), b_Q, bq[i]);
      chk($sformatf("b.tc%0d", i), b_tc, bt[i]);
      chk($sformatf("b.busy%0d", i), b_busy, 1);
    end
    chk("b.tc_count", tcs, 3);

    // abort, then full-range period 7: tc on edges 7 and 14
    b_ab = 1; b_T = 0;
    step();
    b_ab = 0;
    chk("b.abort.busy", b_busy, 0);
    chk("b.abort.rdy", b_rdy, 1);
    b_lv = 1; b_lval = 3'd7; b_T = 1;
    step();
    b_lv = 0;
    chk("b.ld7.Q", b_Q, 7);
    tcs = 0;
    for (int i = 1; i <= 14; i++) begin
      step();
      tcs += b_tc;
      chk($sformatf("b7.tc%0d", i), b_tc, (i % 7 == 0) ? 1 : 0);
      chk($sformatf("b7.Q%0d", i), b_Q, (i % 7 == 0) ? 7 : 7 - (i % 7));
      chk($sformatf("b7.zero%0d", i), b_zero, 0);
    end
    chk("b7.tc_count", tcs, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
